// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the EX-stage multi-cycle divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int unsigned StallBus = 6;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) that stalls EX while an operation runs
// and delivers {remainder, quotient} for the HI/LO write path.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_t         r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic               r_sign1;
    logic               r_sign2;
    logic               r_signed;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH+1:0]   w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    always_comb begin
        w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
        w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;

        // Dividend register doubles as the quotient: MSB shifts out, new bit shifts in.
        w_partial   = {r_rem, r_dividend[WIDTH-1]};
        w_sub       = {1'b0, w_partial} - {2'b00, r_divisor};
        w_ge        = ~|w_sub[WIDTH+1:WIDTH];
        w_rem_next  = w_ge ? w_sub[WIDTH-1:0] : w_partial[WIDTH-1:0];
        w_quot_next = {r_dividend[WIDTH-2:0], w_ge};

        w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? negate(w_quot_next) : w_quot_next;
        w_rem_fix  = (r_signed && r_sign1) ? negate(w_rem_next) : w_rem_next;
    end

    // Result and ready are registered on the transition into END, so both are
    // visible during the END cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_count    <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_signed   <= 1'b0;
            r_result   <= '0;
            r_ready    <= DivResultNotReady;
        end else begin
            r_ready <= DivResultNotReady;
            case (r_state)
                DIV_FREE: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state    <= DIV_ON;
                            r_count    <= '0;
                            r_dividend <= w_abs1;
                            r_divisor  <= w_abs2;
                            r_rem      <= '0;
                            r_sign1    <= opdata1_i[WIDTH-1];
                            r_sign2    <= opdata2_i[WIDTH-1];
                            r_signed   <= signed_i;
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_result <= '0;
                        r_ready  <= DivResultReady;
                        r_state  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= w_quot_next;
                        r_count    <= r_count + CW'(1);
                        if (r_count == CW'(WIDTH - 1)) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= DivResultReady;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    r_state <= DIV_FREE;
                end
                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of model results checked on each ready pulse.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_tests;
    int n_fail;
    logic [63:0] exp_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts an op in the current cycle (cycle 1), waits for ready_o, checks latency,
    // stall behaviour and result. With keep=1, start_i stays high afterwards.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit keep, input string name);
        int cyc;
        int exp_cyc;
        bit seen;
        bit stall_ok;
        logic [63:0] exp;
        exp_q.push_back(model(sgn, a, b));
        exp_cyc   = (b == 32'd0) ? 3 : 34;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        seen      = 1'b0;
        stall_ok  = 1'b1;
        cyc       = 0;
        while (!seen && cyc < 60) begin
            cyc++;
            @(negedge clk);
            if (ready_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stallreq_o !== 1'b1) stall_ok = 1'b0;
                @(posedge clk); #1;
            end
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: ready_o never rose within 60 cycles, required cycle %0d", name, exp_cyc);
        end else begin
            if (cyc !== exp_cyc) begin
                n_fail++;
                $display("FAIL %s_latency: ready_o in cycle %0d, required cycle %0d", name, cyc, exp_cyc);
            end
            n_tests++;
            if (result_o !== exp) begin
                n_fail++;
                $display("FAIL %s_result: got %h, required %h", name, result_o, exp);
            end
            n_tests++;
            if (stallreq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_stall_at_ready: got %b, required 0", name, stallreq_o);
            end
        end
        n_tests++;
        if (!stall_ok) begin
            n_fail++;
            $display("FAIL %s_stall_busy: stallreq_o dropped before ready, required 1", name);
        end
        @(posedge clk); #1;
        if (!keep) start_i = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (result_o !== 64'd0 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: result %h ready %b, required 0 0", result_o, ready_o);
        end
        n_tests++;
        if (stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall_idle: got %b, required 0", stallreq_o);
        end
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        #1;
        n_tests++;
        if (stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_comb: got %b, required 1", stallreq_o);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        run_op(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b0, "divu_max_16");
    endtask

    task automatic test_signed();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, "div_m7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    endtask

    task automatic test_divzero();
        run_op(1'b0, 32'd5, 32'd0, 1'b0, "divu_5_0");
    endtask

    task automatic test_annul();
        logic [63:0] prior;
        bit ok;
        run_op(1'b0, 32'd50, 32'd6, 1'b0, "divu_50_6");
        prior     = model(1'b0, 32'd50, 32'd6);
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_stall: got %b, required 0", stallreq_o);
        end
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || result_o !== prior) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL annul_no_result: ready %b result %h, required 0 %h", ready_o, result_o, prior);
        end
        @(posedge clk); #1;
        run_op(1'b0, 32'd9, 32'd4, 1'b0, "divu_9_4_after_annul");
    endtask

    task automatic test_midop_reset();
        signed_i  = 1'b1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'hFFFF_FFFD;
        start_i   = 1'b1;
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (result_o !== 64'd0 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: result %h ready %b, required 0 0", result_o, ready_o);
        end
        n_tests++;
        if (stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset_stall_hi: got %b, required 1", stallreq_o);
        end
        start_i = 1'b0;
        #1;
        n_tests++;
        if (stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_stall_lo: got %b, required 0", stallreq_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b0, "div_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 32'd15, 32'd4, 1'b1, "b2b_15_4");
        run_op(1'b0, 32'd16, 32'd4, 1'b0, "b2b_16_4");
    endtask

    task automatic test_hold();
        logic [63:0] last;
        bit ok;
        last = model(1'b0, 32'd16, 32'd4);
        ok   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || result_o !== last) ok = 1'b0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_result: ready %b result %h, required 0 %h", ready_o, result_o, last);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_midop_reset();
        test_back_to_back();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
